// File: rtl/cnn_mem_pkg.sv
// Shared constants and types for the per-channel bias/scale parameter fetch path.
package cnn_mem_pkg;

  localparam int DEF_BIAS_WIDTH  = 32;
  localparam int DEF_SCALE_WIDTH = 16;
  localparam int DEF_LAYER_NUM   = 8;
  localparam int DEF_CH_NUM      = 64;

  localparam int LAYER_W = 5;
  localparam int CH_W    = 10;
  localparam int CNT_W   = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/bs_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is presented on dout whenever empty is low.
module bs_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bias_scale_fetch_ctrl.sv
// Walks channels 0..N-1 of one layer in the bias/scale ROM and streams the returned words in order.
module bias_scale_fetch_ctrl
  import cnn_mem_pkg::*;
#(
  parameter int BIAS_WIDTH  = DEF_BIAS_WIDTH,
  parameter int SCALE_WIDTH = DEF_SCALE_WIDTH,
  parameter int LAYER_NUM   = DEF_LAYER_NUM,
  parameter int CH_NUM      = DEF_CH_NUM,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [LAYER_W-1:0]     cfg_layer,
  input  logic [CNT_W-1:0]       cfg_ch_count,
  input  logic                   abort,
  output logic                   mem_start,
  output logic [LAYER_W-1:0]     mem_layer_idx,
  output logic [CH_W-1:0]        mem_ch_idx,
  input  logic                   mem_valid,
  input  logic [BIAS_WIDTH-1:0]  mem_bias,
  input  logic [SCALE_WIDTH-1:0] mem_scale,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIAS_WIDTH-1:0]  out_bias,
  output logic [SCALE_WIDTH-1:0] out_scale,
  output logic [CH_W-1:0]        out_ch_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  localparam int ENTRY_W = BIAS_WIDTH + SCALE_WIDTH + CH_W + 1;
  localparam int OCC_W   = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e state, state_nxt;

  logic [LAYER_W-1:0]     layer_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       issue_ch;
  logic [CNT_W-1:0]       ret_ch;
  logic [OCC_W-1:0]       inflight;
  logic [OCC_W-1:0]       fifo_count;
  logic                   discard;
  logic                   done_q;
  logic                   cfg_bad, accept, issue, credit_ok, flush;
  logic                   push, pop, last_pop, fifo_empty;
  logic [ENTRY_W-1:0]     push_data, head;
  logic [BIAS_WIDTH-1:0]  head_bias;
  logic [SCALE_WIDTH-1:0] head_scale;
  logic [CH_W-1:0]        head_ch;
  logic                   head_last;

  assign cfg_bad   = (cfg_layer >= LAYER_W'(LAYER_NUM)) || (cfg_ch_count > CNT_W'(CH_NUM));
  assign flush     = abort && (state != ST_IDLE);
  // Reads issued but not yet landed count against FIFO space, so a push can never overflow.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (OCC_W+1)'(FIFO_DEPTH);
  assign push      = mem_valid && !discard && (state != ST_IDLE);
  assign pop       = out_valid && out_ready;
  assign last_pop  = (state == ST_DRAIN) && !abort && pop && out_last;
  assign push_data = {mem_bias, mem_scale, ret_ch[CH_W-1:0], ret_ch == count_q - CNT_W'(1)};

  // NOTE: every always_comb output gets a default before the case so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_valid && !cfg_bad && (cfg_ch_count != '0)) begin
          accept    = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (credit_ok) begin
          issue = 1'b1;
          if (issue_ch == count_q - CNT_W'(1)) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort || last_pop) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_q       <= '0;
      count_q       <= '0;
      issue_ch      <= '0;
      ret_ch        <= '0;
      inflight      <= '0;
      discard       <= 1'b0;
      done_q        <= 1'b0;
      cfg_err       <= 1'b0;
      mem_start     <= 1'b0;
      mem_layer_idx <= '0;
      mem_ch_idx    <= '0;
    end else begin
      mem_start <= issue;
      done_q    <= (state == ST_IDLE) && cfg_valid && !cfg_bad && (cfg_ch_count == '0);
      cfg_err   <= (state == ST_IDLE) && cfg_valid && cfg_bad;
      // A read launched just before abort returns one cycle later and must not land.
      discard   <= flush;
      if (accept) begin
        layer_q  <= cfg_layer;
        count_q  <= cfg_ch_count;
        issue_ch <= '0;
        ret_ch   <= '0;
      end
      if (issue) begin
        mem_layer_idx <= layer_q;
        mem_ch_idx    <= issue_ch[CH_W-1:0];
        issue_ch      <= issue_ch + CNT_W'(1);
      end
      if (push) ret_ch <= ret_ch + CNT_W'(1);
      if (flush) inflight <= '0;
      else       inflight <= inflight + OCC_W'(issue) - OCC_W'(push);
    end
  end

  bs_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_bias, head_scale, head_ch, head_last} = head;

  // Head fields read as zero while empty so the unreset storage never shows on the stream.
  assign out_valid  = !fifo_empty;
  assign out_bias   = out_valid ? head_bias  : '0;
  assign out_scale  = out_valid ? head_scale : '0;
  assign out_ch_idx = out_valid ? head_ch    : '0;
  assign out_last   = out_valid && head_last;

  assign cfg_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = done_q || last_pop;

endmodule

// File: tb/tb_bias_scale_fetch_ctrl.sv
// Directed bench for bias_scale_fetch_ctrl with a 1-cycle ROM model and an in-order stream scoreboard.
module tb_bias_scale_fetch_ctrl;

  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [31:0] bias;
    logic [15:0] scale;
    logic [9:0]  ch;
    logic        last;
  } entry_t;

  logic        clk, rst_n;
  logic        cfg_valid, cfg_ready;
  logic [4:0]  cfg_layer;
  logic [10:0] cfg_ch_count;
  logic        abort;
  logic        mem_start;
  logic [4:0]  mem_layer_idx;
  logic [9:0]  mem_ch_idx;
  logic        mem_valid;
  logic [31:0] mem_bias;
  logic [15:0] mem_scale;
  logic        out_valid, out_ready;
  logic [31:0] out_bias;
  logic [15:0] out_scale;
  logic [9:0]  out_ch_idx;
  logic        out_last, busy, done, cfg_err;

  bias_scale_fetch_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_layer(cfg_layer),
    .cfg_ch_count(cfg_ch_count), .abort(abort),
    .mem_start(mem_start), .mem_layer_idx(mem_layer_idx), .mem_ch_idx(mem_ch_idx),
    .mem_valid(mem_valid), .mem_bias(mem_bias), .mem_scale(mem_scale),
    .out_valid(out_valid), .out_ready(out_ready), .out_bias(out_bias),
    .out_scale(out_scale), .out_ch_idx(out_ch_idx), .out_last(out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model state
  entry_t       exp_q[$];
  int           exp_layer = 0, exp_count = 0, issue_ptr = 0;
  int           job_issued = 0, job_popped = 0;
  int           n_issue = 0, n_pop = 0, n_done = 0;
  int           issue_cyc[$];
  int           pop_cyc[$];
  logic [63:0]  pop_data[$];
  int           cfg_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  function automatic logic [31:0] rom_bias(input int layer, input int ch);
    return 32'hB1A5_0000 | 32'(layer * 64 + ch);
  endfunction

  function automatic logic [15:0] rom_scale(input int layer, input int ch);
    return 16'h5C00 + 16'(layer * 64 + ch);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ROM: data for the address presented with mem_start appears one cycle later.
  initial begin
    int pend_v, pend_l, pend_c;
    pend_v = 0; pend_l = 0; pend_c = 0;
    mem_valid = 1'b0; mem_bias = '0; mem_scale = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_valid = (pend_v != 0);
      mem_bias  = pend_v != 0 ? rom_bias(pend_l, pend_c) : 32'h0;
      mem_scale = pend_v != 0 ? rom_scale(pend_l, pend_c) : 16'h0;
      pend_v = int'(mem_start);
      pend_l = int'(mem_layer_idx);
      pend_c = int'(mem_ch_idx);
    end
  end

  // Compare process: checks every issue, every accepted stream entry and the credit bound.
  always @(negedge clk) begin
    entry_t e;
    logic [63:0] got;
    if (rst_n) begin
      if (done) n_done++;
      if (mem_start) begin
        n_issue++;
        job_issued++;
        issue_cyc.push_back(cyc);
        check("issue_in_range", 64'(issue_ptr < exp_count), 64'd1);
        check("issue_addr", 64'({mem_layer_idx, mem_ch_idx}),
              64'({exp_layer[4:0], issue_ptr[9:0]}));
        issue_ptr++;
      end
      if (out_valid && out_ready) begin
        n_pop++;
        job_popped++;
        pop_cyc.push_back(cyc);
        got = 64'({out_bias, out_scale, out_ch_idx, out_last});
        pop_data.push_back(got);
        if (exp_q.size() == 0) begin
          check("stream_expected_entries", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("stream_entry", got, 64'(e));
          check("done_with_last", 64'(done), 64'(e.last));
        end
      end
      check("credit_bound", 64'((job_issued - job_popped) <= FIFO_DEPTH), 64'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int layer, input int cnt);
    int k;
    entry_t e;
    k = 0;
    step();
    while (!cfg_ready && k < 200) begin step(); k++; end
    check("cfg_ready_before_job", 64'(cfg_ready), 64'd1);
    cfg_valid = 1'b1;
    cfg_layer = 5'(layer);
    cfg_ch_count = 11'(cnt);
    cfg_cyc = cyc;
    if (layer < 8 && cnt <= 64 && cnt > 0) begin
      exp_layer = layer; exp_count = cnt; issue_ptr = 0;
      job_issued = 0; job_popped = 0;
      for (int ch = 0; ch < cnt; ch++) begin
        e.bias = rom_bias(layer, ch);
        e.scale = rom_scale(layer, ch);
        e.ch = 10'(ch);
        e.last = (ch == cnt - 1);
        exp_q.push_back(e);
      end
    end
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while ((busy || out_valid) && k < 3000);
    check(name, 64'(busy || out_valid), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
    check({tag, "_busy_done_err"}, 64'({busy, done, cfg_err}), 64'd0);
    check({tag, "_mem_if"}, 64'({mem_start, mem_layer_idx, mem_ch_idx}), 64'd0);
    check({tag, "_stream"}, 64'({out_valid, out_bias, out_scale, out_ch_idx, out_last}), 64'd0);
  endtask

  task automatic reject_case(input int layer, input int cnt, input bit expect_err);
    int i0, d0;
    i0 = n_issue; d0 = n_done;
    start_job(layer, cnt);
    @(negedge clk);
    check("rej_cfg_err", 64'(cfg_err), 64'(expect_err));
    check("rej_done", 64'(done), 64'(!expect_err));
    check("rej_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("rej_pulse_end", 64'({cfg_err, done}), 64'd0);
    repeat (3) @(negedge clk);
    check("rej_no_issue", 64'(n_issue - i0), 64'd0);
    check("rej_done_count", 64'(n_done - d0), 64'(expect_err ? 0 : 1));
  endtask

  initial begin
    int p0, d0, i0, k;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_layer = '0; cfg_ch_count = '0;
    abort = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #3 rst_n = 1'b1;

    // Basic job: layer 2, 4 channels, consumer always ready.
    issue_cyc.delete(); pop_cyc.delete(); pop_data.delete();
    d0 = n_done;
    start_job(2, 4);
    wait_idle("basic_idle");
    check("basic_first_issue_lat", 64'(issue_cyc[0] - cfg_cyc), 64'd2);
    for (int i = 1; i < 4; i++)
      check("basic_issue_b2b", 64'(issue_cyc[i] - issue_cyc[0]), 64'(i));
    check("basic_first_out_lat", 64'(pop_cyc[0] - cfg_cyc), 64'd4);
    check("basic_out_b2b", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);
    check("basic_ch0_literal", pop_data[0], 64'({32'hB1A5_0080, 16'h5C80, 10'd0, 1'b0}));
    check("basic_ch3_literal", pop_data[3], 64'({32'hB1A5_0083, 16'h5C83, 10'd3, 1'b1}));
    check("basic_pops", 64'(pop_data.size()), 64'd4);
    check("basic_done_count", 64'(n_done - d0), 64'd1);

    // Backpressure: only FIFO_DEPTH reads may be issued while the consumer stalls.
    out_ready = 1'b0;
    i0 = n_issue; p0 = n_pop; d0 = n_done;
    start_job(2, 8);
    repeat (10) step();
    @(negedge clk);
    check("bp_issue_count", 64'(n_issue - i0), 64'd4);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_mem_start_low", 64'(mem_start), 64'd0);
    step();
    out_ready = 1'b1;
    wait_idle("bp_idle");
    check("bp_pops", 64'(n_pop - p0), 64'd8);
    check("bp_done_count", 64'(n_done - d0), 64'd1);

    // Rejected and empty jobs.
    reject_case(8, 4, 1'b1);
    reject_case(3, 65, 1'b1);
    reject_case(3, 0, 1'b0);

    // Abort two cycles after the first issue.
    i0 = n_issue; d0 = n_done;
    start_job(3, 64);
    k = 0;
    while (n_issue == i0 && k < 50) begin @(negedge clk); k++; end
    check("abort_first_issue_seen", 64'(n_issue - i0), 64'd1);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_q.delete(); exp_count = 0; issue_ptr = 0;
    @(negedge clk);
    check("abort_state", 64'({busy, out_valid, mem_start, done}), 64'd0);
    check("abort_cfg_ready", 64'(cfg_ready), 64'd1);
    repeat (5) @(negedge clk);
    check("abort_no_done", 64'(n_done - d0), 64'd0);
    check("abort_quiet", 64'({busy, out_valid}), 64'd0);
    p0 = n_pop;
    start_job(1, 2);
    wait_idle("post_abort_idle");
    check("post_abort_pops", 64'(n_pop - p0), 64'd2);
    check("post_abort_done", 64'(n_done - d0), 64'd1);

    // Full-length job with a random consumer.
    p0 = n_pop; d0 = n_done;
    start_job(7, 64);
    for (int j = 0; j < 2000 && (n_pop - p0) < 64; j++) begin
      step();
      out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    wait_idle("rand_idle");
    check("rand_pops", 64'(n_pop - p0), 64'd64);
    check("rand_done_count", 64'(n_done - d0), 64'd1);

    // Reset in the middle of FETCH, then a clean job.
    out_ready = 1'b0;
    start_job(5, 64);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete(); exp_count = 0; issue_ptr = 0;
    job_issued = 0; job_popped = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    p0 = n_pop; d0 = n_done;
    start_job(6, 3);
    wait_idle("post_reset_idle");
    check("post_reset_pops", 64'(n_pop - p0), 64'd3);
    check("post_reset_done", 64'(n_done - d0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
